jk_counter: RTL and testbench

JK_COUNTER -- requirements
Module: jk_counter

---
 rtl/jk_counter_pkg.sv | 19 +
 rtl/jk_cell.sv | 29 ++
 rtl/jk_counter.sv | 93 +++++++++
 tb/tb_jk_counter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/jk_counter_pkg.sv
// Shared types for the JK counter: operation modes and JK pair encodings.
// Down counting is enabled with the JK_COUNTER_DOWN_EN macro.
package jk_counter_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    JKBIT = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TOG  = 2'b11
  } jk_e;

endpackage

// File: rtl/jk_cell.sv
// One falling-edge JK flip-flop with synchronous active-high clear.
// Used by jk_counter; JK_COUNTER_DOWN_EN has no effect here.
module jk_cell
  import jk_counter_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk_n,
  input  logic clr,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(negedge clk_n) begin
    if (clr) begin
      q <= RESET_BIT;
    end else begin
      unique case (jk_e'({j, k}))
        JK_HOLD: q <= q;
        JK_CLR:  q <= 1'b0;
        JK_SET:  q <= 1'b1;
        JK_TOG:  q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_counter.sv
// Modulo counter / loadable register built from per-bit JK cells.
// Define JK_COUNTER_DOWN_EN to honour UP=0 (down counting) in COUNT mode.
module jk_counter
  import jk_counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 2 ** WIDTH,
  parameter int RESET_VAL = 0
) (
  input  logic             CLK_N,
  input  logic             CLR,
  input  logic [1:0]       MODE,
  input  logic             UP,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_BAR,
  output logic             TC
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST = WIDTH'(RESET_VAL);

  mode_e            mode;
  logic             up_eff;
  logic [WIDTH-1:0] cnt_up;
  logic [WIDTH-1:0] cnt_dn;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] cj;
  logic [WIDTH-1:0] ck;

  assign mode = mode_e'(MODE);

`ifdef JK_COUNTER_DOWN_EN
  assign up_eff = UP;
`else
  logic unused_up;
  assign unused_up = UP;
  assign up_eff    = 1'b1;
`endif

  // Loaded values >= MODULUS fall back to zero on the next up count
  assign cnt_up = (Q >= MAX) ? '0 : Q + 1'b1;
  assign cnt_dn = (Q == '0) ? MAX : Q - 1'b1;

  // Target value maps onto J/K as set (10) or clear (01) per bit
  always_comb begin
    nxt = Q;
    cj  = '0;
    ck  = '0;
    unique case (mode)
      HOLD: begin
        cj = '0;
        ck = '0;
      end
      LOAD: begin
        cj = D;
        ck = ~D;
      end
      COUNT: begin
        nxt = up_eff ? cnt_up : cnt_dn;
        cj  = nxt;
        ck  = ~nxt;
      end
      JKBIT: begin
        cj = J;
        ck = K;
      end
      default: begin
        cj = '0;
        ck = '0;
      end
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell #(
      .RESET_BIT(RST[i])
    ) u_cell (
      .clk_n(CLK_N),
      .clr  (CLR),
      .j    (cj[i]),
      .k    (ck[i]),
      .q    (Q[i])
    );
  end

  assign Q_BAR = ~Q;
  assign TC    = (mode == COUNT) &&
                 (up_eff ? (Q == MAX) : (Q == '0));

endmodule

// File: tb/tb_jk_counter.sv
// Scoreboard bench for jk_counter (WIDTH=4, MODULUS=10).
// Build with or without JK_COUNTER_DOWN_EN to select the UP=0 vectors.
module tb_jk_counter;
  import jk_counter_pkg::*;

  logic       CLK_N = 1'b1;
  logic       CLR;
  logic [1:0] MODE;
  logic       UP;
  logic [3:0] D;
  logic [3:0] J;
  logic [3:0] K;
  logic [3:0] Q;
  logic [3:0] Q_BAR;
  logic       TC;

  typedef struct {
    string      name;
    logic [3:0] q;
    logic       tc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK_N = ~CLK_N;

  jk_counter #(
    .WIDTH    (4),
    .MODULUS  (10),
    .RESET_VAL(0)
  ) dut (
    .CLK_N(CLK_N),
    .CLR  (CLR),
    .MODE (MODE),
    .UP   (UP),
    .D    (D),
    .J    (J),
    .K    (K),
    .Q    (Q),
    .Q_BAR(Q_BAR),
    .TC   (TC)
  );

  // Inputs change after the rising edge; the falling edge is active.
  task automatic step(input string nm, input logic clr,
                      input logic [1:0] m, input logic up,
                      input logic [3:0] d, input logic [3:0] j,
                      input logic [3:0] k, input logic [3:0] eq,
                      input logic etc);
    @(posedge CLK_N);
    #1;
    CLR  = clr;
    MODE = m;
    UP   = up;
    D    = d;
    J    = j;
    K    = k;
    @(negedge CLK_N);
    sb.push_back('{nm, eq, etc});
  endtask

  // Monitor: results are sampled on the rising edge, half a cycle
  // after the falling edge that produced them.
  always @(posedge CLK_N) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (Q !== e.q) begin
        errors++;
        $display("FAIL %s Q got %h want %h", e.name, Q, e.q);
      end
      checks++;
      if (Q_BAR !== ~e.q) begin
        errors++;
        $display("FAIL %s Q_BAR got %h want %h", e.name, Q_BAR, ~e.q);
      end
      checks++;
      if (TC !== e.tc) begin
        errors++;
        $display("FAIL %s TC got %b want %b", e.name, TC, e.tc);
      end
    end
  end

  initial begin
    CLR  = 1'b0;
    MODE = HOLD;
    UP   = 1'b1;
    D    = '0;
    J    = '0;
    K    = '0;

    step("reset", 1'b1, LOAD, 1'b1, 4'd7, 4'd0, 4'd0, 4'd0, 1'b0);
    for (int v = 1; v <= 11; v++) begin
      step("count_up", 1'b0, COUNT, 1'b1, 4'd0, 4'd0, 4'd0,
           4'(v % 10), (v % 10) == 9);
    end

    step("load4", 1'b0, LOAD, 1'b1, 4'd4, 4'd0, 4'd0, 4'd4, 1'b0);
    step("count5", 1'b0, COUNT, 1'b1, 4'd0, 4'd0, 4'd0, 4'd5, 1'b0);
    step("clr_prio", 1'b1, LOAD, 1'b1, 4'd7, 4'd0, 4'd0, 4'd0, 1'b0);
    step("after_clr", 1'b0, COUNT, 1'b1, 4'd0, 4'd0, 4'd0, 4'd1, 1'b0);

    // hold / toggle / set / clear across bits 3..0
    step("load_a", 1'b0, LOAD, 1'b1, 4'b1010, 4'd0, 4'd0, 4'b1010, 1'b0);
    step("jkbit", 1'b0, JKBIT, 1'b1, 4'd0, 4'b0110, 4'b0101,
         4'b1110, 1'b0);
    step("jk_tog", 1'b0, JKBIT, 1'b1, 4'd0, 4'b1111, 4'b1111,
         4'b0001, 1'b0);

    step("load13", 1'b0, LOAD, 1'b1, 4'd13, 4'd0, 4'd0, 4'd13, 1'b0);
    step("wrap13", 1'b0, COUNT, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("hold", 1'b0, HOLD, 1'b1, 4'd5, 4'd0, 4'd0, 4'd0, 1'b0);
    end

    step("load8", 1'b0, LOAD, 1'b1, 4'd8, 4'd0, 4'd0, 4'd8, 1'b0);
    step("tc9", 1'b0, COUNT, 1'b1, 4'd0, 4'd0, 4'd0, 4'd9, 1'b1);
    step("tc_hold", 1'b0, HOLD, 1'b1, 4'd0, 4'd0, 4'd0, 4'd9, 1'b0);

`ifdef JK_COUNTER_DOWN_EN
    step("load2", 1'b0, LOAD, 1'b0, 4'd2, 4'd0, 4'd0, 4'd2, 1'b0);
    step("dn1", 1'b0, COUNT, 1'b0, 4'd0, 4'd0, 4'd0, 4'd1, 1'b0);
    step("dn0", 1'b0, COUNT, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    step("dn9", 1'b0, COUNT, 1'b0, 4'd0, 4'd0, 4'd0, 4'd9, 1'b0);
    step("dn8", 1'b0, COUNT, 1'b0, 4'd0, 4'd0, 4'd0, 4'd8, 1'b0);
`else
    step("load3", 1'b0, LOAD, 1'b0, 4'd3, 4'd0, 4'd0, 4'd3, 1'b0);
    step("ign_up4", 1'b0, COUNT, 1'b0, 4'd0, 4'd0, 4'd0, 4'd4, 1'b0);
    step("ign_up5", 1'b0, COUNT, 1'b0, 4'd0, 4'd0, 4'd0, 4'd5, 1'b0);
    step("load0", 1'b0, LOAD, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    step("ign_up1", 1'b0, COUNT, 1'b0, 4'd0, 4'd0, 4'd0, 4'd1, 1'b0);
`endif

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge CLK_N);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
